// File: rtl/spi_pwm_multi.sv
// spi_pwm_multi: multi-channel edge/center PWM with double-buffered duties, configured over a mode-0 SPI slave
module spi_pwm_multi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sclk,
    input  logic                ss_n,
    input  logic                mosi,
    output logic                miso,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);
    logic [2:0]       sclk_sync, ss_sync;
    logic [1:0]       mosi_sync;
    logic             active, wr_pend, miso_q;
    logic [4:0]       bit_cnt;
    logic [23:0]      rx;
    logic [15:0]      tx, rd_data;
    logic [6:0]       rd_addr, wr_addr;
    logic             sclk_rise, sclk_fall, ss_fall, ss_high, shift_in, shift_out, commit, ctrl_wr;
    logic [1:0]       ctrl;
    logic [7:0]       prescale, pre_cnt;
    logic [WIDTH-1:0] period, period_s, cnt, cnt_n;
    logic [WIDTH-1:0] duty [CHANNELS];
    logic [WIDTH-1:0] duty_s [CHANNELS];
    logic [CHANNELS-1:0] pwm_cmp;
    logic             en, center, dir, dir_n, tick, wrap, at_top, at_zero;

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign ss_fall   = ~ss_sync[1] & ss_sync[2];
    assign ss_high   = ss_sync[1];
    assign shift_in  = active & ~ss_high & sclk_rise & (bit_cnt < 5'd24);
    assign shift_out = active & ~ss_high & sclk_fall & (bit_cnt >= 5'd8) & (bit_cnt < 5'd24);
    assign rd_addr   = {rx[5:0], mosi_sync[1]};
    assign wr_addr   = rx[22:16];
    assign commit    = wr_pend & ~rx[23];
    assign ctrl_wr   = commit && wr_addr == 7'h00;
    assign miso      = miso_q & ~ss_n;
    assign en        = ctrl[0];
    assign center    = ctrl[1];
    assign tick      = en && pre_cnt >= prescale;
    assign at_top    = cnt >= period_s;
    assign at_zero   = cnt == '0;

    // Two-flop synchronisers plus one delay stage for edge detection; left unreset so a
    // reset with ss_n held low does not look like a fresh frame start.
    always_ff @(posedge clk) begin
        sclk_sync <= {sclk_sync[1:0], sclk};
        ss_sync   <= {ss_sync[1:0], ss_n};
        mosi_sync <= {mosi_sync[0], mosi};
    end

    // SPI framing: shift in on sclk rise, load readback after 8 bits, shift out on sclk fall
    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= 1'b0;
            bit_cnt <= '0;
            wr_pend <= 1'b0;
            rx      <= '0;
            tx      <= '0;
            miso_q  <= 1'b0;
        end else begin
            wr_pend <= shift_in && bit_cnt == 5'd23;
            if (ss_fall) begin
                active  <= 1'b1;
                bit_cnt <= '0;
                tx      <= '0;
                miso_q  <= 1'b0;
            end else if (ss_high) begin
                active <= 1'b0;
            end else if (shift_in) begin
                rx      <= {rx[22:0], mosi_sync[1]};
                bit_cnt <= bit_cnt + 5'd1;
                if (bit_cnt == 5'd7)
                    tx <= rx[6] ? rd_data : '0;
            end else if (shift_out) begin
                miso_q <= tx[15];
                tx     <= {tx[14:0], 1'b0};
            end
        end
    end

    // Readback mux of the active registers, zero-extended to 16 bits
    always_comb begin
        rd_data = rd_addr == 7'h00 ? 16'(ctrl) :
                  rd_addr == 7'h01 ? 16'(prescale) :
                  rd_addr == 7'h02 ? 16'(period) : '0;
        for (int i = 0; i < CHANNELS; i++)
            if (rd_addr == 7'(16 + i))
                rd_data = 16'(duty[i]);
    end

    // Active register file, written one clk after the 24th bit of a write frame
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= '0;
            prescale <= '0;
            period   <= '1;
            for (int i = 0; i < CHANNELS; i++)
                duty[i] <= '0;
        end else if (commit) begin
            if (wr_addr == 7'h00)
                ctrl <= rx[1:0];
            if (wr_addr == 7'h01)
                prescale <= rx[7:0];
            if (wr_addr == 7'h02)
                period <= rx[WIDTH-1:0];
            for (int i = 0; i < CHANNELS; i++)
                if (wr_addr == 7'(16 + i))
                    duty[i] <= rx[WIDTH-1:0];
        end
    end

    // Next counter state: edge mode wraps at TOP, center mode dwells one tick at TOP and at 0
    always_comb begin
        cnt_n = !center ? (at_top ? '0 : cnt + WIDTH'(1)) :
                !dir    ? (at_top ? cnt : cnt + WIDTH'(1)) :
                          (at_zero ? cnt : cnt - WIDTH'(1));
        dir_n = center && (dir ? !at_zero : at_top);
        wrap  = !center ? at_top : dir ? cnt == WIDTH'(1) : at_top && at_zero;
    end

    // Per-channel compare against the shadow duties
    always_comb begin
        pwm_cmp = '0;
        for (int i = 0; i < CHANNELS; i++)
            pwm_cmp[i] = cnt < duty_s[i];
    end

    // Prescaler, counter, shadow loading and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt      <= '0;
            cnt          <= '0;
            dir          <= 1'b0;
            pwm_out      <= '0;
            period_start <= 1'b0;
            period_s     <= '1;
            for (int i = 0; i < CHANNELS; i++)
                duty_s[i] <= '0;
        end else begin
            pre_cnt      <= (en && !tick) ? pre_cnt + 8'd1 : 8'd0;
            cnt          <= !en ? '0 : tick ? cnt_n : cnt;
            dir          <= (!en || ctrl_wr) ? 1'b0 : tick ? dir_n : dir;
            pwm_out      <= en ? pwm_cmp : '0;
            period_start <= tick && wrap;
            if (!en || (tick && wrap)) begin
                period_s <= period;
                duty_s   <= duty;
            end
        end
    end
endmodule

// File: tb/tb_spi_pwm_multi.sv
// tb_spi_pwm_multi: directed SPI configuration and PWM waveform checks for spi_pwm_multi
module tb_spi_pwm_multi;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclk = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [3:0] pwm_out;
    logic       period_start;

    int          vectors = 0;
    int          errors = 0;
    int          highs [4];
    logic [31:0] pat [4];
    int          ps_seen;
    logic [15:0] rd;

    spi_pwm_multi #(.CHANNELS(4), .WIDTH(8)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .pwm_out(pwm_out), .period_start(period_start)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [23:0] f, input int n, output logic [15:0] r);
        r = '0;
        for (int i = 0; i < n; i++) begin
            mosi = f[23-i];
            tick_n(4);
            if (i >= 8)
                r[23-i] = miso;
            sclk = 1'b1;
            tick_n(8);
            sclk = 1'b0;
            tick_n(4);
        end
    endtask

    task automatic spi_xfer(input logic rw, input logic [6:0] addr, input logic [15:0] data,
                            input int n, output logic [15:0] r);
        ss_n = 1'b0;
        tick_n(8);
        spi_bits({rw, addr, data}, n, r);
        tick_n(4);
        ss_n = 1'b1;
        tick_n(8);
    endtask

    task automatic wr(input logic [6:0] addr, input logic [15:0] data);
        logic [15:0] dummy;
        spi_xfer(1'b0, addr, data, 24, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [6:0] addr, input logic [15:0] exp);
        logic [15:0] r;
        spi_xfer(1'b1, addr, 16'h0000, 24, r);
        chk(tag, 32'(r), 32'(exp));
    endtask

    task automatic wait_ps(input int lim, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (period_start !== 1'b1 && n < lim);
        chk(tag, 32'(period_start), 32'd1);
    endtask

    task automatic measure(input int len);
        ps_seen = 0;
        for (int c = 0; c < 4; c++) begin
            highs[c] = 0;
            pat[c] = '0;
        end
        for (int k = 0; k < len; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (pwm_out[c] === 1'b1)
                    highs[c]++;
                if (k < 32)
                    pat[c][k] = pwm_out[c];
            end
            if (period_start === 1'b1)
                ps_seen++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        int h;
        tick_n(5);
        reset = 1'b0;
        tick_n(2);

        chk("reset pwm_out", 32'(pwm_out), 32'd0);
        chk("reset period_start", 32'(period_start), 32'd0);
        chk("reset miso idle", 32'(miso), 32'd0);
        rd_chk("reset PERIOD", 7'h02, 16'h00FF);
        rd_chk("reset CTRL", 7'h00, 16'h0000);
        rd_chk("reset DUTY0", 7'h10, 16'h0000);

        wr(7'h02, 16'h0009);
        wr(7'h10, 16'hAB03);
        wr(7'h01, 16'h0000);
        wr(7'h00, 16'h0001);
        wait_ps(200, "edge first boundary");
        measure(10);
        chk("edge duty3 pattern", pat[0][9:0], 32'b0000001110);
        chk("edge duty0 channel2", 32'(highs[2]), 32'd0);
        chk("edge one boundary per period", 32'(ps_seen), 32'd1);
        chk("edge period length 10", 32'(period_start), 32'd1);

        wr(7'h12, 16'h000A);
        wait_ps(200, "extreme boundary");
        measure(10);
        chk("duty above top high", 32'(highs[2]), 32'd10);
        chk("edge duty3 unchanged", pat[0][9:0], 32'b0000001110);

        wr(7'h01, 16'h0063);
        wait_ps(3000, "slow boundary");
        wr(7'h10, 16'h0007);
        chk("dbuf current period low", 32'(pwm_out[0]), 32'd0);
        n = 0;
        h = 0;
        do begin
            if (pwm_out[0] === 1'b1)
                h++;
            @(negedge clk);
            n++;
        end while (period_start !== 1'b1 && n < 2000);
        chk("dbuf old duty rest of period", 32'(h), 32'd0);
        chk("dbuf next boundary", 32'(period_start), 32'd1);
        measure(1000);
        chk("dbuf new duty7 highs", 32'(highs[0]), 32'd700);
        chk("dbuf prescaled period", 32'(ps_seen), 32'd1);
        chk("dbuf period length 1000", 32'(period_start), 32'd1);

        wr(7'h01, 16'h0000);
        wr(7'h02, 16'h0004);
        wr(7'h11, 16'h0002);
        wr(7'h00, 16'h0003);
        wait_ps(200, "center boundary a");
        wait_ps(200, "center boundary b");
        measure(10);
        chk("center duty2 pattern", pat[1][9:0], 32'b0000001111);
        chk("center duty7 over top4", 32'(highs[0]), 32'd10);
        chk("center one boundary", 32'(ps_seen), 32'd1);
        chk("center period length 10", 32'(period_start), 32'd1);

        spi_xfer(1'b0, 7'h10, 16'h0055, 20, rd);
        rd_chk("short frame discarded", 7'h10, 16'h0007);
        wr(7'h7F, 16'h00AA);
        rd_chk("unmapped reads zero", 7'h7F, 16'h0000);
        rd_chk("CTRL readback", 7'h00, 16'h0003);
        rd_chk("DUTY1 readback", 7'h11, 16'h0002);
        rd_chk("PERIOD readback", 7'h02, 16'h0004);

        ss_n = 1'b0;
        tick_n(8);
        spi_bits({1'b0, 7'h10, 16'h0033}, 10, rd);
        reset = 1'b1;
        tick_n(2);
        reset = 1'b0;
        tick_n(2);
        spi_bits({1'b0, 7'h10, 16'h0033}, 24, rd);
        tick_n(4);
        ss_n = 1'b1;
        tick_n(8);
        chk("midframe reset pwm_out", 32'(pwm_out), 32'd0);
        chk("midframe reset period_start", 32'(period_start), 32'd0);
        rd_chk("midframe reset DUTY0", 7'h10, 16'h0000);
        rd_chk("midframe reset PERIOD", 7'h02, 16'h00FF);
        rd_chk("midframe reset CTRL", 7'h00, 16'h0000);
        rd_chk("midframe reset DUTY2", 7'h12, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/spi_pwm_multi.md
# spi_pwm_multi

Multi-channel PWM generator configured over a mode-0 SPI slave port, all in a single system clock domain. It is the parametrised successor to the team's single-purpose SPI PWM block and adds:
- generic channel count and counter width;
- a programmable period and clock prescaler;
- edge- or center-aligned modes;
- double-buffered duty registers that update only at a period boundary;
- register readback on MISO.

It sits directly behind the chip's SPI pins and drives the PWM pad outputs.

## Interface
- `CHANNELS`, default 4, number of PWM outputs (1..16).
- `WIDTH`, default 8, counter/period/duty width in bits (4..16).
- `clk`  in  1  system clock; SPI inputs are oversampled on it.
- `reset`  in  1  synchronous, active-high reset.
- `sclk`  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to `clk`.
- `ss_n`  in  1  SPI slave select, active low, asynchronous.
- `mosi`  in  1  SPI data in, MSB first, asynchronous.
- `miso`  out  1  SPI data out, MSB first; 0 whenever `ss_n` is high.
- `pwm_out`  out  CHANNELS  PWM outputs; bit i is channel i.
- `period_start`  out  1  one-`clk` pulse at every period boundary (shadow load instant).

## Operation
- **Synchronisation.** `sclk`, `ss_n` and `mosi` each pass through a 2-flop synchroniser. `sclk` edges are detected on the synchronised copy. Requirement: `clk` ≥ 8× `sclk`.
- **Frame format.** Every frame is 24 bits, framed by `ss_n` low:
  - bit 23 = R/W (1 = read);
  - bits 22:16 = address;
  - bits 15:0 = data.
  - `mosi` is sampled on detected `sclk` rising edges.
- **Write.** Commits in the cycle after the 24th rising edge. Only data[WIDTH-1:0] is used; upper data bits are ignored.
- **Read.**
  - After the 8th rising edge, the addressed register is loaded, zero-extended to 16 bits, into the TX shift register.
  - `miso` shifts on detected `sclk` falling edges.
  - bit 15 is driven from the falling edge after the 8th rising edge.
  - The read returns the active (written) value, not the shadow value.
- **Frame errors.**
  - `ss_n` rising before 24 bits: frame discarded, no register change.
  - Edges after the 24th bit and before `ss_n` rises are ignored.
  - `ss_n` falling always restarts the bit count.
- **Register map.** Unmapped addresses read 0; writes to them are ignored.
  - 0x00 CTRL: bit0 = EN, bit1 = CENTER.
  - 0x01 PRESCALE: 8 bits; the counter advances once per PRESCALE+1 `clk`.
  - 0x02 PERIOD: TOP.
  - 0x10+i DUTY[i], for i < CHANNELS.
- **Shadowing.**
  - PERIOD and DUTY[i] have shadow copies.
  - Shadows load at each period boundary, and continuously while EN=0.
  - CTRL and PRESCALE take effect immediately.
- **Edge mode (CENTER=0).**
  - cnt runs 0..TOP_s, then wraps to 0.
  - Boundary = tick where cnt wraps to 0.
  - `pwm_out[i]` = (cnt < DUTY_s[i]).
  - Period = (TOP_s+1) ticks.
- **Center mode (CENTER=1).**
  - cnt counts up 0→TOP_s, then down TOP_s→0.
  - The TOP_s and 0 values are each held for one tick.
  - Boundary = tick where cnt goes to 0 from the down phase.
  - `pwm_out[i]` = (cnt < DUTY_s[i]).
  - Period = 2·(TOP_s+1) ticks.
- **Boundary duties.**
  - DUTY = 0: output constant low.
  - DUTY > TOP_s: output constant high.
- **EN = 0.** cnt held at 0, prescaler held at 0, direction = up, `pwm_out` = 0, `period_start` = 0.
- **Mode change.** Writing CENTER mid-period: cnt continues from its current value in the new mode with direction = up.

## Timing
- **Reset values.**
  - CTRL = 0, PRESCALE = 0, PERIOD = 2^WIDTH−1, DUTY = 0, shadows equal to these.
  - cnt = 0, `pwm_out` = 0, `miso` = 0, `period_start` = 0.
  - Bit counter cleared.
- **Reset mid-frame** aborts the frame; the next frame needs a fresh `ss_n` fall.
- **Input latency.** Pin edge to internal edge detect is 3 `clk`.
- **Write latency.** The register updates on the `clk` after the 24th edge is detected.
- **`pwm_out` is registered.** It changes 1 `clk` after the cnt value that causes the change.
- **`period_start`** is high for the single `clk` in which shadows load, aligned with cnt becoming 0.
- **Enable.** EN 0→1 via SPI: the first tick occurs PRESCALE+1 `clk` after the CTRL commit.
- **Simultaneous write and boundary.** A write committing in the same `clk` as a boundary goes to the active register only; the shadow takes the pre-write value and picks up the new value at the next boundary.

## Test plan
- **Reset check.** Reset, then read addr 0x02 → `miso` returns 0x00FF (WIDTH=8); all `pwm_out` = 0; `period_start` = 0.
- **Edge-mode duty.** Write PERIOD=9, DUTY0=3, PRESCALE=0, CTRL=0x01.
  - `pwm_out[0]` is high 3 of every 10 `clk`.
  - `period_start` pulses every 10 `clk`.
- **Center-mode duty.** CTRL=0x03, PERIOD=4, DUTY1=2.
  - Period = 10 `clk`.
  - `pwm_out[1]` is high for 4 `clk`, symmetric about the cnt=0 instant.
- **Double buffering.** With a period running, write DUTY0=7 mid-period.
  - The current period keeps duty 3.
  - The next period after `period_start` shows duty 7.
- **Duty extremes.** DUTY2=0 → `pwm_out[2]` constant 0; DUTY2=10 with PERIOD=9 → constant 1.
- **Frame robustness.**
  - Raise `ss_n` after 20 bits of a write to 0x10 → DUTY0 unchanged on readback.
  - Write to 0x7F → ignored, and readback of 0x7F = 0.
  - Assert reset mid-frame → all registers return to reset values.
